pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Fetch/execute controller for the 8-bit CPU core. Owns the architectural PC register and
//  drives the program-counter pass-through path to instruction memory and the ALU.
//  Issues one instruction fetch over a req/ack handshake, then waits for execute completion.
//  Selects the next PC from sequential, conditional branch, jump or return.
// PARAMETERS
//  ADDR_W     8     PC / instruction address width
//  RESET_VEC  8'h00 PC value loaded on reset
//  RAS_DEPTH  4     return-address stack entries (used only with PC_RAS_EN)
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  imem_req     out  1       fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc while imem_req)
//  imem_ack     in   1       instruction memory has returned data this cycle
//  instr_valid  out  1       1-cycle pulse: fetched instruction ready for decode
//  exec_done    in   1       execute stage finished current instruction
//  next_sel     in   2       00 seq, 01 cond branch, 10 jump, 11 return
//  br_taken     in   1       branch condition (qualifies next_sel=01)
//  target       in   ADDR_W  branch/jump target
//  push         in   1       with next_sel=10: call, push pc+1
//  halt         in   1       stop after current instruction
//  pc           out  ADDR_W  current PC
//  halted       out  1       core stopped
//  stack_err    out  1       sticky RAS overflow/underflow flag
// BEHAVIOUR
//  - Reset (async, any state): pc=RESET_VEC, state=IDLE; imem_req, instr_valid, halted,
//    stack_err all 0; RAS emptied. Reset mid-fetch drops imem_req immediately.
//  - FSM (state enum in package): IDLE -> FETCH (always, 1 cycle).
//    FETCH: imem_req=1, imem_addr=pc. On imem_ack -> EXEC, instr_valid pulses that same cycle.
//    EXEC: wait for exec_done. On exec_done, pc updates on that edge.
//    Go to HALT if halt=1 that cycle, else FETCH.
//    HALT: halted=1, imem_req=0. Exits only via reset.
//  - Fetch latency: minimum 1 cycle (ack in first FETCH cycle). Minimum instruction period is 2 cycles.
//  - imem_ack outside FETCH is ignored. exec_done outside EXEC is ignored.
//  - Next PC on exec_done: 00 pc+1; 01 br_taken ? target : pc+1; 10 target; 11 see CONFIGURATION.
//  - Arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00, with no flag.
//  - halt and exec_done in the same cycle: the PC update still happens, then HALT.
// CONFIGURATION
//  PC_RAS_EN defined:
//  - push with next_sel=10 pushes pc+1.
//  - next_sel=11 pops the top entry into pc.
//  - Push when full: push dropped, jump still taken, stack_err<=1.
//  - Pop when empty: pc<=pc+1, stack_err<=1.
//  - stack_err clears only on reset.
//  PC_RAS_EN undefined: next_sel=11 acts as 00, push ignored, stack_err tied 0, no RAS storage.
// STRUCTURE
//  - cpu_pkg: ADDR_W default, seq_state_t {IDLE,FETCH,EXEC,HALT}, NSEL_* encodings.
//  - Sub-module pc_ras (LIFO, RAS_DEPTH x ADDR_W, push/pop/full/empty), instantiated only
//    under PC_RAS_EN. Next-PC mux and FSM live in pc_sequencer.
// TESTING
//  1 Reset release, ack after 2 cycles -> imem_req 1 from cycle 1, imem_addr=00,
//    instr_valid pulses once.
//  2 Sequential run: four instrs, all next_sel=00 -> pc 00,01,02,03,04.
//    pc=FF, seq -> pc=00.
//  3 pc=10, next_sel=01: br_taken=1, target=40 -> pc=40.
//    br_taken=0 -> pc=11. next_sel=10, target=80 -> pc=80.
//  4 PC_RAS_EN: call from 20 to 50 (push), then return -> pc=21.
//    Five calls with depth 4 -> stack_err=1. Return on empty -> pc+1, stack_err=1.
//  5 halt with exec_done at pc=05 -> pc=06, halted=1, no further imem_req
//    despite ack/exec_done stimulus.
//  6 rst_n low while imem_req=1 -> imem_req 0 without clock edge.
//    Release -> fetch from RESET_VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8-bit CPU core fetch/execute control.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } seq_state_t;

  localparam logic [1:0] NSEL_SEQ = 2'b00;
  localparam logic [1:0] NSEL_BR  = 2'b01;
  localparam logic [1:0] NSEL_JMP = 2'b10;
  localparam logic [1:0] NSEL_RET = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH x W LIFO. Push on full and pop on empty are ignored;
// the caller flags them. DEPTH must be at least 2.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = cnt[IDX_W-1:0];
  assign rd_idx = wr_idx - ONE_IDX;
  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == {CNT_W{1'b0}});
  assign top    = mem[rd_idx];

  // Stack storage and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      cnt         <= cnt + ONE_CNT;
    end else if (pop && !empty) begin
      cnt <= cnt - ONE_CNT;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning the architectural PC and next-PC selection.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic [1:0]        next_sel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] target,
  input  logic              push,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_err
);

  seq_state_t        state;
  seq_state_t        next_state;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_full;
  logic              ras_empty;
  logic              err_set;
  logic [ADDR_W-1:0] ras_top;
  logic              err_q;

  pc_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (seq_pc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Sticky stack misuse flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
  assign stack_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = push & (RAS_DEPTH > 0);
  assign stack_err  = 1'b0;
`endif

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_VEC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // Next-state, next-PC and handshake decode
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    instr_valid = 1'b0;
`ifdef PC_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        if (imem_ack) begin
          next_state  = EXEC;
          instr_valid = 1'b1;
        end else begin
          next_state = FETCH;
        end
      end
      EXEC: begin
        if (exec_done) begin
          next_state = halt ? HALT : FETCH;
          case (next_sel)
            NSEL_SEQ: next_pc = seq_pc;
            NSEL_BR:  next_pc = br_taken ? target : seq_pc;
            NSEL_JMP: begin
              next_pc = target;
`ifdef PC_RAS_EN
              // A call on a full stack still jumps; only the return address is lost
              if (push) begin
                ras_push = !ras_full;
                err_set  = ras_full;
              end else begin
                ras_push = 1'b0;
              end
`endif
            end
            NSEL_RET: begin
`ifdef PC_RAS_EN
              if (ras_empty) begin
                next_pc = seq_pc;
                err_set = 1'b1;
              end else begin
                next_pc = ras_top;
                ras_pop = 1'b1;
              end
`else
              next_pc = seq_pc;
`endif
            end
            default: next_pc = seq_pc;
          endcase
        end else begin
          next_state = EXEC;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

endmodule
